goose_game_ctrl: RTL and testbench

- Game-state controller directly downstream of the goose/bean collision detector.
- Consumes the raw, pixel-rate `hit` level from that detector and folds it into one event per frame.
- Maintains lives, score, invulnerability window and speed level, and sequences IDLE/RUN/HIT/OVER.
- Outputs drive the sprite renderer (blink), obstacle spawner (speed) and score display.

---
 rtl/goose_pkg.sv | 18 +
 rtl/rise_edge.sv | 26 ++
 rtl/goose_game_ctrl.sv | 124 ++++++++++++
 tb/tb_goose_game_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/goose_pkg.sv
// Shared definitions for the goose game: FSM state encoding and default game constants,
// also used by the sprite renderer and score display.
package goose_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } game_state_t;

   localparam int DEF_LIVES         = 3;
   localparam int DEF_INVULN_FRAMES = 90;
   localparam int DEF_SCORE_W       = 14;
   localparam int DEF_SPEED_SHIFT   = 9;
   localparam int SPEED_MAX         = 7;

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector for already-debounced button levels; produces a one-cycle pulse.
module rise_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic pulse
);

   logic prev;
   logic armed;

   // A button held through reset release must not count as a press, so the detector
   // only arms after it has seen the input low at least once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev  <= 1'b0;
         armed <= 1'b0;
      end else begin
         prev <= in;
         if (!in) armed <= 1'b1;
      end
   end

   assign pulse = in & ~prev & armed;

endmodule

// File: rtl/goose_game_ctrl.sv
// Game-state controller: folds the pixel-rate hit level into one event per frame and
// tracks lives, score, invulnerability window and speed level.
module goose_game_ctrl
   import goose_pkg::*;
#(
   parameter int LIVES         = DEF_LIVES,
   parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
   parameter int SCORE_W       = DEF_SCORE_W,
   parameter int SPEED_SHIFT   = DEF_SPEED_SHIFT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic               hit,
   output logic [1:0]         state,
   output logic [2:0]         lives,
   output logic [SCORE_W-1:0] score,
   output logic               invuln,
   output logic [2:0]         speed_lvl,
   output logic               game_over,
   output logic               hit_evt
);

   game_state_t        state_q;
   game_state_t        state_nx;
   logic [2:0]         lives_nx;
   logic [SCORE_W-1:0] score_nx;
   logic [SCORE_W-1:0] score_inc;
   logic [SCORE_W-1:0] score_shr;
   logic [7:0]         cnt_q;
   logic [7:0]         cnt_nx;
   logic               hit_pend;
   logic               hit_pend_nx;
   logic               hit_evt_nx;
   logic               start_rise;
   logic               eff_hit;

   rise_edge u_start_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (start_btn),
      .pulse (start_rise)
   );

   assign eff_hit   = hit_pend | hit;
   assign score_inc = (score == {SCORE_W{1'b1}}) ? score : score + SCORE_W'(1);

   // State, counters and the registered outputs all share one reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         lives    <= 3'(LIVES);
         score    <= '0;
         cnt_q    <= '0;
         hit_pend <= 1'b0;
         hit_evt  <= 1'b0;
      end else begin
         state_q  <= state_nx;
         lives    <= lives_nx;
         score    <= score_nx;
         cnt_q    <= cnt_nx;
         hit_pend <= hit_pend_nx;
         hit_evt  <= hit_evt_nx;
      end
   end

   // Next-state logic. Hits only accumulate while running, so anything seen during
   // invulnerability is dropped rather than charged on the first vulnerable frame.
   always_comb begin
      state_nx    = state_q;
      lives_nx    = lives;
      score_nx    = score;
      cnt_nx      = cnt_q;
      hit_pend_nx = 1'b0;
      hit_evt_nx  = 1'b0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_rise) begin
               state_nx = ST_RUN;
               lives_nx = 3'(LIVES);
               score_nx = '0;
               cnt_nx   = '0;
            end
         end
         ST_RUN: begin
            hit_pend_nx = eff_hit & ~frame_tick;
            if (frame_tick) begin
               if (eff_hit) begin
                  hit_evt_nx = 1'b1;
                  if (lives <= 3'd1) begin
                     state_nx = ST_OVER;
                     lives_nx = 3'd0;
                  end else begin
                     state_nx = ST_HIT;
                     lives_nx = lives - 3'd1;
                     cnt_nx   = 8'(INVULN_FRAMES);
                  end
               end else begin
                  score_nx = score_inc;
               end
            end
         end
         ST_HIT: begin
            if (frame_tick) begin
               score_nx = score_inc;
               cnt_nx   = cnt_q - 8'd1;
               if (cnt_q <= 8'd1) begin
                  state_nx = ST_RUN;
                  cnt_nx   = '0;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign score_shr = score >> SPEED_SHIFT;
   assign speed_lvl = (score_shr > SCORE_W'(SPEED_MAX)) ? 3'd7 : score_shr[2:0];
   assign state     = state_q;
   assign invuln    = (state_q == ST_HIT);
   assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_goose_game_ctrl.sv
// Self-checking bench: two controller instances (default and small parameters) share
// stimulus and are compared against a frame-rule reference model plus directed constants.
module tb_goose_game_ctrl;

   localparam int FP = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_tick = 1'b0;
   logic start_btn = 1'b0;
   logic hit = 1'b0;

   logic [1:0]  st0, st1;
   logic [2:0]  lives0, lives1, spd0, spd1;
   logic [13:0] score0;
   logic [3:0]  score1;
   logic        inv0, inv1, go0, go1, evt0, evt1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tick_count = 0;
   int evt_cnt0 = 0;
   int last_evt_tick0 = 0;
   int g_start = 0;
   bit hit_lvl = 1'b0;
   bit hit_tick_only = 1'b0;

   // Reference model state, one slot per instance; states numbered 0=IDLE 1=RUN 2=HIT 3=OVER.
   int m_st[2], m_lives[2], m_score[2], m_cnt[2];
   bit m_pend[2], m_evt[2];
   bit m_prev, m_seen_low;
   int P_LIVES[2] = '{3, 2};
   int P_INV[2]   = '{90, 3};
   int P_MAX[2]   = '{16383, 15};
   int P_SS[2]    = '{9, 2};

   goose_game_ctrl u0 (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn), .hit(hit),
      .state(st0), .lives(lives0), .score(score0), .invuln(inv0), .speed_lvl(spd0),
      .game_over(go0), .hit_evt(evt0)
   );

   goose_game_ctrl #(.LIVES(2), .INVULN_FRAMES(3), .SCORE_W(4), .SPEED_SHIFT(2)) u1 (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn), .hit(hit),
      .state(st1), .lives(lives1), .score(score1), .invuln(inv1), .speed_lvl(spd1),
      .game_over(go1), .hit_evt(evt1)
   );

   always #5 clk = ~clk;

   // Frame-level game rules applied once per clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_lives[k] = P_LIVES[k]; m_score[k] = 0; m_cnt[k] = 0;
            m_pend[k] = 1'b0; m_evt[k] = 1'b0;
         end
         m_prev = 1'b0;
         m_seen_low = 1'b0;
      end else begin
         bit rise;
         rise = start_btn && !m_prev && m_seen_low;
         for (int k = 0; k < 2; k++) begin
            bit eff;
            int old;
            eff = m_pend[k] || hit;
            old = m_st[k];
            m_evt[k] = 1'b0;
            if ((old == 0 || old == 3) && rise) begin
               m_st[k] = 1; m_lives[k] = P_LIVES[k]; m_score[k] = 0; m_cnt[k] = 0;
            end else if (old == 1 && frame_tick) begin
               if (eff) begin
                  m_evt[k] = 1'b1;
                  m_lives[k] = m_lives[k] - 1;
                  if (m_lives[k] == 0) m_st[k] = 3;
                  else begin m_st[k] = 2; m_cnt[k] = P_INV[k]; end
               end else if (m_score[k] < P_MAX[k]) m_score[k]++;
            end else if (old == 2 && frame_tick) begin
               if (m_score[k] < P_MAX[k]) m_score[k]++;
               m_cnt[k]--;
               if (m_cnt[k] == 0) m_st[k] = 1;
            end
            m_pend[k] = (old == 1 && !frame_tick) ? (m_pend[k] || hit) : 1'b0;
         end
         m_prev = start_btn;
         if (!start_btn) m_seen_low = 1'b1;
      end
   end

   always @(posedge clk) if (rst_n && frame_tick) tick_count++;

   always @(negedge clk) begin
      if (evt0 === 1'b1) begin
         evt_cnt0++;
         last_evt_tick0 = tick_count;
      end
   end

   function automatic int model_speed(input int k);
      int s;
      s = m_score[k] >> P_SS[k];
      return (s > 7) ? 7 : s;
   endfunction

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         frame_tick = (cyc % FP == FP - 1);
         hit = hit_tick_only ? frame_tick : hit_lvl;
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_start();
      start_btn = 1'b1;
      run_cycles(1);
      start_btn = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hit_lvl = 1'b0; start_btn = 1'b0;
      run_cycles(3);
      checks++; if (st0 !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", st0); end
      checks++; if (lives0 !== 3'd3) begin errors++; $display("[TB] FAIL reset_lives got %0d want 3", lives0); end
      checks++; if (score0 !== 14'd0) begin errors++; $display("[TB] FAIL reset_score got %0d want 0", score0); end
      checks++; if ({inv0, go0, evt0} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {inv0, go0, evt0}); end
      checks++; if (spd0 !== 3'd0) begin errors++; $display("[TB] FAIL reset_speed got %0d want 0", spd0); end
      checks++; if (lives1 !== 3'd2) begin errors++; $display("[TB] FAIL reset_lives1 got %0d want 2", lives1); end
      rst_n = 1'b1;
      run_cycles(3);
   endtask

   task automatic test_clean_frames();
      int base;
      base = evt_cnt0;
      press_start();
      g_start = tick_count;
      checks++; if (st0 !== 2'd1) begin errors++; $display("[TB] FAIL start_latency got %0d want 1", st0); end
      while (tick_count < g_start + 10) run_cycles(1);
      checks++; if (st0 !== 2'd1) begin errors++; $display("[TB] FAIL clean_state got %0d want 1", st0); end
      checks++; if (score0 !== 14'd10) begin errors++; $display("[TB] FAIL clean_score got %0d want 10", score0); end
      checks++; if (lives0 !== 3'd3) begin errors++; $display("[TB] FAIL clean_lives got %0d want 3", lives0); end
      checks++; if (evt_cnt0 != base) begin errors++; $display("[TB] FAIL clean_no_evt got %0d want %0d", evt_cnt0, base); end
      checks++; if (score1 !== 4'd10) begin errors++; $display("[TB] FAIL clean_score1 got %0d want 10", score1); end
   endtask

   task automatic test_saturation();
      while (tick_count < g_start + 20) run_cycles(1);
      checks++; if (score1 !== 4'd15) begin errors++; $display("[TB] FAIL sat_score1 got %0d want 15", score1); end
      checks++; if (spd1 !== 3'd3) begin errors++; $display("[TB] FAIL sat_speed1 got %0d want 3", spd1); end
      checks++; if (score0 !== 14'd20) begin errors++; $display("[TB] FAIL sat_score0 got %0d want 20", score0); end
      checks++; if (spd0 !== 3'd0) begin errors++; $display("[TB] FAIL sat_speed0 got %0d want 0", spd0); end
   endtask

   task automatic test_hit_window();
      int base, l;
      base = evt_cnt0;
      hit_lvl = 1'b1;
      run_cycles(500);
      hit_lvl = 1'b0;
      l = last_evt_tick0;
      checks++; if (evt_cnt0 - base != 1) begin errors++; $display("[TB] FAIL window_evts got %0d want 1", evt_cnt0 - base); end
      checks++; if (lives0 !== 3'd2) begin errors++; $display("[TB] FAIL window_lives got %0d want 2", lives0); end
      checks++; if (st0 !== 2'd2 || inv0 !== 1'b1) begin errors++; $display("[TB] FAIL window_state got %0d/%b want 2/1", st0, inv0); end
      checks++; if (go1 !== 1'b1 || lives1 !== 3'd0) begin errors++; $display("[TB] FAIL window_small_over got %b/%0d want 1/0", go1, lives1); end
      while (tick_count < l + 89) run_cycles(1);
      checks++; if (st0 !== 2'd2 || inv0 !== 1'b1) begin errors++; $display("[TB] FAIL invuln_89 got %0d/%b want 2/1", st0, inv0); end
      while (tick_count < l + 90) run_cycles(1);
      checks++; if (st0 !== 2'd1 || inv0 !== 1'b0) begin errors++; $display("[TB] FAIL invuln_end got %0d/%b want 1/0", st0, inv0); end
      checks++; if (int'(score0) != l - 1 - g_start + 90) begin errors++; $display("[TB] FAIL window_score got %0d want %0d", score0, l - 1 - g_start + 90); end
   endtask

   task automatic test_three_hits();
      int tc, s;
      bit ok;
      while (cyc % FP != 5) run_cycles(1);
      hit_lvl = 1'b1;
      run_cycles(1);
      hit_lvl = 1'b0;
      checks++; if (lives0 !== 3'd2) begin errors++; $display("[TB] FAIL pulse_pending got %0d want 2", lives0); end
      tc = tick_count;
      while (tick_count == tc) run_cycles(1);
      checks++; if (evt0 !== 1'b1 || lives0 !== 3'd1 || st0 !== 2'd2) begin errors++; $display("[TB] FAIL pulse_loss got evt%b lives%0d st%0d want 1/1/2", evt0, lives0, st0); end
      ok = 1'b0;
      for (int i = 0; i < 100 * FP && !ok; i++) begin
         run_cycles(1);
         if (st0 === 2'd1) ok = 1'b1;
      end
      checks++; if (!ok) begin errors++; $display("[TB] FAIL wait_run got %0d want 1", st0); end
      hit_tick_only = 1'b1;
      tc = tick_count;
      while (tick_count == tc) run_cycles(1);
      hit_tick_only = 1'b0;
      checks++; if (evt0 !== 1'b1 || st0 !== 2'd3) begin errors++; $display("[TB] FAIL coincident_over got evt%b st%0d want 1/3", evt0, st0); end
      checks++; if (lives0 !== 3'd0 || go0 !== 1'b1) begin errors++; $display("[TB] FAIL over_flags got %0d/%b want 0/1", lives0, go0); end
      s = int'(score0);
      run_cycles(5 * FP);
      checks++; if (int'(score0) != s || st0 !== 2'd3) begin errors++; $display("[TB] FAIL over_frozen got %0d/%0d want %0d/3", score0, st0, s); end
      press_start();
      checks++; if (st0 !== 2'd1 || lives0 !== 3'd3 || score0 !== 14'd0) begin errors++; $display("[TB] FAIL restart got %0d/%0d/%0d want 1/3/0", st0, lives0, score0); end
   endtask

   task automatic test_reset_mid_hit();
      int l;
      hit_tick_only = 1'b1;
      l = tick_count;
      while (tick_count == l) run_cycles(1);
      hit_tick_only = 1'b0;
      l = tick_count;
      while (tick_count < l + 50) run_cycles(1);
      checks++; if (st0 !== 2'd2) begin errors++; $display("[TB] FAIL midhit_state got %0d want 2", st0); end
      #3;
      rst_n = 1'b0;
      start_btn = 1'b1;
      #1;
      checks++; if (st0 !== 2'd0 || lives0 !== 3'd3 || score0 !== 14'd0) begin errors++; $display("[TB] FAIL async_reset got %0d/%0d/%0d want 0/3/0", st0, lives0, score0); end
      checks++; if (inv0 !== 1'b0) begin errors++; $display("[TB] FAIL async_invuln got %b want 0", inv0); end
      run_cycles(3);
      rst_n = 1'b1;
      run_cycles(5);
      checks++; if (st0 !== 2'd0) begin errors++; $display("[TB] FAIL held_btn got %0d want 0", st0); end
      start_btn = 1'b0;
      run_cycles(1);
      press_start();
      checks++; if (st0 !== 2'd1) begin errors++; $display("[TB] FAIL new_edge got %0d want 1", st0); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         hit_lvl = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 149) == 0) start_btn = ~start_btn;
         run_cycles(1);
         checks++; if (st0 !== 2'(m_st[0])) begin errors++; $display("[TB] FAIL rnd_state0 got %0d want %0d", st0, m_st[0]); end
         checks++; if (lives0 !== 3'(m_lives[0])) begin errors++; $display("[TB] FAIL rnd_lives0 got %0d want %0d", lives0, m_lives[0]); end
         checks++; if (score0 !== 14'(m_score[0])) begin errors++; $display("[TB] FAIL rnd_score0 got %0d want %0d", score0, m_score[0]); end
         checks++; if (evt0 !== m_evt[0]) begin errors++; $display("[TB] FAIL rnd_evt0 got %b want %b", evt0, m_evt[0]); end
         checks++; if (inv0 !== (m_st[0] == 2) || go0 !== (m_st[0] == 3)) begin errors++; $display("[TB] FAIL rnd_flags0 got %b%b want st %0d", inv0, go0, m_st[0]); end
         checks++; if (st1 !== 2'(m_st[1])) begin errors++; $display("[TB] FAIL rnd_state1 got %0d want %0d", st1, m_st[1]); end
         checks++; if (lives1 !== 3'(m_lives[1])) begin errors++; $display("[TB] FAIL rnd_lives1 got %0d want %0d", lives1, m_lives[1]); end
         checks++; if (score1 !== 4'(m_score[1])) begin errors++; $display("[TB] FAIL rnd_score1 got %0d want %0d", score1, m_score[1]); end
         checks++; if (evt1 !== m_evt[1]) begin errors++; $display("[TB] FAIL rnd_evt1 got %b want %b", evt1, m_evt[1]); end
         checks++; if (spd1 !== 3'(model_speed(1))) begin errors++; $display("[TB] FAIL rnd_speed1 got %0d want %0d", spd1, model_speed(1)); end
         checks++; if (inv1 !== (m_st[1] == 2) || go1 !== (m_st[1] == 3)) begin errors++; $display("[TB] FAIL rnd_flags1 got %b%b want st %0d", inv1, go1, m_st[1]); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_frames();
      test_saturation();
      test_hit_window();
      test_three_hits();
      test_reset_mid_hit();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
